obi_ifdata_arbiter: RTL and testbench

//  Shares one single-ported OBI memory between the core instruction and data OBI manager interfaces.

---
 rtl/obi_ifdata_arbiter_pkg.sv | 30 +++
 rtl/obi_ifdata_arbiter_if.sv | 28 ++
 rtl/obi_ifdata_arbiter_id_fifo.sv | 61 ++++++
 rtl/obi_ifdata_arbiter.sv | 146 ++++++++++++++
 tb/tb_obi_ifdata_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_ifdata_arbiter_pkg.sv
// Shared types and constants for the instruction/data OBI arbiter.
package obi_ifdata_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned RCHK_W = 5;

    // Instruction fetches are always full-word reads.
    localparam logic [BE_W-1:0] INSTR_BE = 4'hF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    // Owner id stored in the response FIFO: 0 = instr, 1 = data.
    function automatic logic owner_id(input owner_e own);
        return (own == OWN_D);
    endfunction

endpackage

// File: rtl/obi_ifdata_arbiter_if.sv
// OBI address/response bundle; master drives the address phase.
interface obi_ifdata_arbiter_if;
    import obi_ifdata_arbiter_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              gntpar;
    logic              rvalid;
    logic              rvalidpar;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [RCHK_W-1:0] rchk;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, gntpar, rvalid, rvalidpar, rdata, err, rchk
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, gntpar, rvalid, rvalidpar, rdata, err, rchk
    );

endinterface

// File: rtl/obi_ifdata_arbiter_id_fifo.sv
// In-order FIFO of 1-bit owner ids for transactions granted but not yet answered.
module obi_ifdata_arbiter_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted only when a pop frees the slot.
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem_q[rptr_q];
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_id;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/obi_ifdata_arbiter.sv
// Shares one OBI memory port between the core instruction and data managers.
module obi_ifdata_arbiter
    import obi_ifdata_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    obi_ifdata_arbiter_if.slave  i_bus,
    obi_ifdata_arbiter_if.slave  d_bus,
    obi_ifdata_arbiter_if.master m_bus,
    output logic                 alert_o
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    owner_e              owner_q;
    owner_e              owner_d;
    owner_e              owner_c;
    logic                run_q;
    logic [STARVE_W-1:0] starve_q;
    logic                alert_q;

    obi_req_t            mux_req;
    logic                sel_req;
    logic                m_req_c;
    logic                grant_c;
    logic                held_drop_c;
    logic                fault_c;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_head;
    logic                fifo_pop;

    // Effective owner: held owner, or this cycle's winner when idle.
    always_comb begin
        owner_c = owner_q;
        if (owner_q == OWN_NONE) begin
            if (i_bus.req && (!d_bus.req || (starve_q == STARVE_W'(STARVE_LIMIT)))) begin
                owner_c = OWN_I;
            end else if (d_bus.req) begin
                owner_c = OWN_D;
            end
        end
    end

    // Request mux and grant qualification.
    always_comb begin
        sel_req = 1'b0;
        mux_req = '0;
        case (owner_c)
            OWN_I: begin
                sel_req      = i_bus.req;
                mux_req.addr = i_bus.addr;
                mux_req.be   = INSTR_BE;
            end
            OWN_D: begin
                sel_req = d_bus.req;
                mux_req = '{addr: d_bus.addr, we: d_bus.we, be: d_bus.be, wdata: d_bus.wdata};
            end
            default: ;
        endcase
        m_req_c     = run_q && sel_req && !fifo_full;
        grant_c     = m_req_c && m_bus.gnt;
        held_drop_c = (owner_q != OWN_NONE) && !sel_req;
    end

    // Owner next state: hold until granted; a dropped held request releases ownership.
    always_comb begin
        owner_d = owner_c;
        if (grant_c || held_drop_c || !run_q) begin
            owner_d = OWN_NONE;
        end
    end

    // Integrity and protocol faults seen this cycle.
    always_comb begin
        fault_c = (m_bus.gntpar == m_bus.gnt)
               || (m_bus.rvalidpar == m_bus.rvalid)
               || (m_bus.rvalid && fifo_empty)
               || held_drop_c;
    end

    // Owner state, starvation counter, run flag and alert pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= OWN_NONE;
            run_q    <= 1'b0;
            starve_q <= '0;
            alert_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            run_q   <= 1'b1;
            alert_q <= fault_c;
            if (grant_c && (owner_c == OWN_I)) begin
                starve_q <= '0;
            end else if (i_bus.req && (owner_c != OWN_I)
                         && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
                starve_q <= starve_q + STARVE_W'(1);
            end
        end
    end

    obi_ifdata_arbiter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (grant_c),
        .push_id (owner_id(owner_c)),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign fifo_pop = m_bus.rvalid && !fifo_empty;

    // Memory-side request.
    assign m_bus.req   = m_req_c;
    assign m_bus.addr  = mux_req.addr;
    assign m_bus.we    = mux_req.we;
    assign m_bus.be    = mux_req.be;
    assign m_bus.wdata = mux_req.wdata;

    // Grant and response routing to the owning port.
    assign i_bus.gnt       = grant_c && (owner_c == OWN_I);
    assign d_bus.gnt       = grant_c && (owner_c == OWN_D);
    assign i_bus.gntpar    = ~i_bus.gnt;
    assign d_bus.gntpar    = ~d_bus.gnt;
    assign i_bus.rvalid    = fifo_pop && !fifo_head;
    assign d_bus.rvalid    = fifo_pop && fifo_head;
    assign i_bus.rvalidpar = ~i_bus.rvalid;
    assign d_bus.rvalidpar = ~d_bus.rvalid;
    assign i_bus.rdata     = m_bus.rdata;
    assign d_bus.rdata     = m_bus.rdata;
    assign i_bus.err       = m_bus.err && i_bus.rvalid;
    assign d_bus.err       = m_bus.err && d_bus.rvalid;
    assign i_bus.rchk      = m_bus.rchk;
    assign d_bus.rchk      = m_bus.rchk;

    assign alert_o = alert_q;

endmodule

// File: tb/tb_obi_ifdata_arbiter.sv
// Directed bench for the instruction/data OBI arbiter.
module tb_obi_ifdata_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic alert;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    obi_ifdata_arbiter_if i_bus ();
    obi_ifdata_arbiter_if d_bus ();
    obi_ifdata_arbiter_if m_bus ();

    obi_ifdata_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .i_bus   (i_bus),
        .d_bus   (d_bus),
        .m_bus   (m_bus),
        .alert_o (alert)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        m_bus.gnt       = gnt;
        m_bus.gntpar    = ~gnt;
        m_bus.rvalid    = rvalid;
        m_bus.rvalidpar = ~rvalid;
        m_bus.rdata     = rdata;
    endtask

    task automatic idle;
        i_bus.req = 1'b0; i_bus.addr = '0; i_bus.we = 1'b0; i_bus.be = '0; i_bus.wdata = '0;
        d_bus.req = 1'b0; d_bus.addr = '0; d_bus.we = 1'b0; d_bus.be = '0; d_bus.wdata = '0;
        m_bus.err = 1'b0; m_bus.rchk = '0;
        mem(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset;
        idle();
        i_bus.req = 1'b1; i_bus.addr = 32'h0000_0400;
        mem(1'b1, 1'b1, 32'h0);
        #3;
        n_tests++; if (i_bus.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_i_gnt got=%0b exp=0", i_bus.gnt); end
        n_tests++; if (i_bus.gntpar !== 1'b1) begin n_fail++; $display("FAIL reset_i_gntpar got=%0b exp=1", i_bus.gntpar); end
        n_tests++; if (m_bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got=%0b exp=0", m_bus.req); end
        n_tests++; if (i_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_i_rvalid got=%0b exp=0", i_bus.rvalid); end
        n_tests++; if (d_bus.rvalidpar !== 1'b1) begin n_fail++; $display("FAIL reset_d_rvalidpar got=%0b exp=1", d_bus.rvalidpar); end
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL reset_alert got=%0b exp=0", alert); end
        idle();
        #2 rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single_instr;
        i_bus.req = 1'b1; i_bus.addr = 32'h0800_0000;
        mem(1'b1, 1'b0, 32'h0);
        #1;
        n_tests++; if (i_bus.gnt !== 1'b1) begin n_fail++; $display("FAIL single_i_gnt got=%0b exp=1", i_bus.gnt); end
        n_tests++; if (i_bus.gntpar !== 1'b0) begin n_fail++; $display("FAIL single_i_gntpar got=%0b exp=0", i_bus.gntpar); end
        n_tests++; if (m_bus.addr !== 32'h0800_0000) begin n_fail++; $display("FAIL single_m_addr got=%h exp=08000000", m_bus.addr); end
        n_tests++; if (m_bus.be !== 4'hF || m_bus.we !== 1'b0) begin n_fail++; $display("FAIL single_m_be_we got=%h/%0b exp=f/0", m_bus.be, m_bus.we); end
        tick();
        i_bus.req = 1'b0;
        mem(1'b0, 1'b1, 32'h01C0_0093);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL single_i_rvalid got=%0b exp=1", i_bus.rvalid); end
        n_tests++; if (i_bus.rvalidpar !== 1'b0) begin n_fail++; $display("FAIL single_i_rvalidpar got=%0b exp=0", i_bus.rvalidpar); end
        n_tests++; if (i_bus.rdata !== 32'h01C0_0093) begin n_fail++; $display("FAIL single_i_rdata got=%h exp=01c00093", i_bus.rdata); end
        n_tests++; if (d_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL single_d_rvalid got=%0b exp=0", d_bus.rvalid); end
        tick();
        idle();
        tick();
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL single_alert got=%0b exp=0", alert); end
    endtask

    task automatic test_starvation;
        logic exp_i;
        logic prev_i;
        prev_i = 1'b0;
        i_bus.req = 1'b1; i_bus.addr = 32'h0000_1000;
        d_bus.req = 1'b1; d_bus.addr = 32'h2000_0000;
        for (int k = 0; k < 10; k++) begin
            mem(1'b1, (k > 0), 32'h0);
            #1;
            exp_i = ((k % 5) == 4);
            n_tests++; if (i_bus.gnt !== exp_i || d_bus.gnt !== !exp_i) begin n_fail++; $display("FAIL starve_gnt cycle=%0d got i=%0b d=%0b exp i=%0b", k, i_bus.gnt, d_bus.gnt, exp_i); end
            n_tests++; if (m_bus.addr !== (exp_i ? 32'h0000_1000 : 32'h2000_0000)) begin n_fail++; $display("FAIL starve_addr cycle=%0d got=%h", k, m_bus.addr); end
            if (k > 0) begin
                n_tests++; if (i_bus.rvalid !== prev_i || d_bus.rvalid !== !prev_i) begin n_fail++; $display("FAIL starve_rvalid cycle=%0d got i=%0b d=%0b exp i=%0b", k, i_bus.rvalid, d_bus.rvalid, prev_i); end
            end
            prev_i = exp_i;
            tick();
        end
        i_bus.req = 1'b0; d_bus.req = 1'b0;
        mem(1'b0, 1'b1, 32'h0);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL starve_last_i_rvalid got=%0b exp=1", i_bus.rvalid); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_hold;
        d_bus.req = 1'b1; d_bus.addr = 32'h2000_0010; d_bus.we = 1'b1; d_bus.be = 4'h3; d_bus.wdata = 32'hDEAD_BEEF;
        mem(1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (m_bus.req !== 1'b1 || m_bus.we !== 1'b1) begin n_fail++; $display("FAIL hold_m_req_we got=%0b/%0b exp=1/1", m_bus.req, m_bus.we); end
        tick();
        for (int k = 1; k <= 3; k++) begin
            i_bus.req = 1'b1; i_bus.addr = 32'h0000_1004;
            #1;
            n_tests++; if (m_bus.addr !== 32'h2000_0010 || m_bus.be !== 4'h3) begin n_fail++; $display("FAIL hold_addr cycle=%0d got=%h/%h exp=20000010/3", k, m_bus.addr, m_bus.be); end
            n_tests++; if (i_bus.gnt !== 1'b0 || d_bus.gnt !== 1'b0) begin n_fail++; $display("FAIL hold_gnt cycle=%0d got i=%0b d=%0b exp 0/0", k, i_bus.gnt, d_bus.gnt); end
            tick();
        end
        mem(1'b1, 1'b0, 32'h0);
        #1;
        n_tests++; if (d_bus.gnt !== 1'b1 || i_bus.gnt !== 1'b0) begin n_fail++; $display("FAIL hold_release got d=%0b i=%0b exp 1/0", d_bus.gnt, i_bus.gnt); end
        n_tests++; if (m_bus.wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hold_wdata got=%h exp=deadbeef", m_bus.wdata); end
        tick();
        d_bus.req = 1'b0;
        mem(1'b1, 1'b1, 32'h0);
        #1;
        n_tests++; if (i_bus.gnt !== 1'b1 || d_bus.rvalid !== 1'b1 || i_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL hold_next got igt=%0b drv=%0b irv=%0b exp 1/1/0", i_bus.gnt, d_bus.rvalid, i_bus.rvalid); end
        tick();
        i_bus.req = 1'b0;
        mem(1'b0, 1'b1, 32'h0);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL hold_i_rvalid got=%0b exp=1", i_bus.rvalid); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_fifo_full;
        i_bus.req = 1'b1; i_bus.addr = 32'h0000_1100;
        mem(1'b1, 1'b0, 32'h0);
        #1;
        n_tests++; if (i_bus.gnt !== 1'b1) begin n_fail++; $display("FAIL full_first_gnt got=%0b exp=1", i_bus.gnt); end
        tick();
        i_bus.req = 1'b0; d_bus.req = 1'b1; d_bus.addr = 32'h2000_2200;
        #1;
        n_tests++; if (d_bus.gnt !== 1'b1) begin n_fail++; $display("FAIL full_second_gnt got=%0b exp=1", d_bus.gnt); end
        tick();
        d_bus.req = 1'b0; i_bus.req = 1'b1; i_bus.addr = 32'h0000_1104;
        #1;
        n_tests++; if (m_bus.req !== 1'b0 || i_bus.gnt !== 1'b0) begin n_fail++; $display("FAIL full_block got m_req=%0b gnt=%0b exp 0/0", m_bus.req, i_bus.gnt); end
        tick();
        mem(1'b1, 1'b1, 32'h0000_000A);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b1 || d_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL full_resp0 got i=%0b d=%0b exp 1/0", i_bus.rvalid, d_bus.rvalid); end
        n_tests++; if (m_bus.req !== 1'b0) begin n_fail++; $display("FAIL full_still_block got=%0b exp=0", m_bus.req); end
        tick();
        mem(1'b1, 1'b1, 32'h0000_000B);
        #1;
        n_tests++; if (d_bus.rvalid !== 1'b1 || i_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL full_resp1 got d=%0b i=%0b exp 1/0", d_bus.rvalid, i_bus.rvalid); end
        n_tests++; if (i_bus.gnt !== 1'b1 || m_bus.addr !== 32'h0000_1104) begin n_fail++; $display("FAIL full_unblock got gnt=%0b addr=%h exp 1/00001104", i_bus.gnt, m_bus.addr); end
        tick();
        i_bus.req = 1'b0;
        mem(1'b0, 1'b1, 32'h0000_000C);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b1 || i_bus.rdata !== 32'h0000_000C) begin n_fail++; $display("FAIL full_resp2 got=%0b/%h exp 1/0000000c", i_bus.rvalid, i_bus.rdata); end
        tick();
        idle();
        tick();
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL full_alert got=%0b exp=0", alert); end
    endtask

    task automatic test_alert;
        mem(1'b0, 1'b1, 32'h0);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b0 || d_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL alert_drop got i=%0b d=%0b exp 0/0", i_bus.rvalid, d_bus.rvalid); end
        tick();
        mem(1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (alert !== 1'b1) begin n_fail++; $display("FAIL alert_empty_pulse got=%0b exp=1", alert); end
        tick();
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL alert_empty_clear got=%0b exp=0", alert); end
        m_bus.gnt = 1'b0; m_bus.gntpar = 1'b0;
        tick();
        mem(1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (alert !== 1'b1) begin n_fail++; $display("FAIL alert_par_pulse got=%0b exp=1", alert); end
        tick();
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL alert_par_clear got=%0b exp=0", alert); end
        d_bus.req = 1'b1; d_bus.addr = 32'h2000_0300;
        tick();
        d_bus.req = 1'b0;
        #1;
        n_tests++; if (m_bus.req !== 1'b0) begin n_fail++; $display("FAIL alert_drop_mreq got=%0b exp=0", m_bus.req); end
        tick();
        n_tests++; if (alert !== 1'b1) begin n_fail++; $display("FAIL alert_proto_pulse got=%0b exp=1", alert); end
        tick();
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL alert_proto_clear got=%0b exp=0", alert); end
        idle();
    endtask

    task automatic test_reset_mid;
        i_bus.req = 1'b1; i_bus.addr = 32'h0000_1200;
        mem(1'b1, 1'b0, 32'h0);
        #1;
        n_tests++; if (i_bus.gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got=%0b exp=1", i_bus.gnt); end
        tick();
        i_bus.req = 1'b0;
        mem(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        d_bus.req = 1'b1; d_bus.addr = 32'h2000_0400;
        mem(1'b1, 1'b1, 32'h0);
        #1;
        n_tests++; if (m_bus.req !== 1'b0 || d_bus.gnt !== 1'b0 || d_bus.gntpar !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got m=%0b g=%0b gp=%0b exp 0/0/1", m_bus.req, d_bus.gnt, d_bus.gntpar); end
        n_tests++; if (i_bus.rvalid !== 1'b0 || i_bus.rvalidpar !== 1'b1 || alert !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp got rv=%0b rvp=%0b al=%0b exp 0/1/0", i_bus.rvalid, i_bus.rvalidpar, alert); end
        idle();
        #1 rst_n = 1'b1;
        tick();
        mem(1'b0, 1'b1, 32'h0);
        #1;
        n_tests++; if (i_bus.rvalid !== 1'b0 || d_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rvalid got i=%0b d=%0b exp 0/0", i_bus.rvalid, d_bus.rvalid); end
        tick();
        mem(1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (alert !== 1'b1) begin n_fail++; $display("FAIL rstmid_alert got=%0b exp=1", alert); end
        tick();
        n_tests++; if (alert !== 1'b0) begin n_fail++; $display("FAIL rstmid_alert_clear got=%0b exp=0", alert); end
    endtask

    initial begin
        test_reset();
        test_single_instr();
        test_starvation();
        test_hold();
        test_fifo_full();
        test_alert();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
